// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbiter that drains per-source result FIFOs onto
//               the single registered CDB broadcast port.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int RoB_WIDTH  = 3,
    parameter int N_SRC      = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       flush_signal,
    input  logic [N_SRC-1:0]           src_push,
    input  logic [N_SRC*RoB_WIDTH-1:0] src_index,
    input  logic [N_SRC*32-1:0]        src_data,
    output logic [N_SRC-1:0]           src_full,
    output logic                       overflow_err,
    output logic                       CDB_update_en,
    output logic [RoB_WIDTH-1:0]       CDB_update_index,
    output logic [31:0]                CDB_update_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

    logic [RoB_WIDTH-1:0] mem_idx_q  [N_SRC][FIFO_DEPTH];
    logic [RoB_WIDTH-1:0] mem_idx_d  [N_SRC][FIFO_DEPTH];
    logic [31:0]          mem_data_q [N_SRC][FIFO_DEPTH];
    logic [31:0]          mem_data_d [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q   [N_SRC];
    logic [PTR_W-1:0]     rd_ptr_d   [N_SRC];
    logic [PTR_W-1:0]     wr_ptr_q   [N_SRC];
    logic [PTR_W-1:0]     wr_ptr_d   [N_SRC];
    logic [CNT_W-1:0]     count_q    [N_SRC];
    logic [CNT_W-1:0]     count_d    [N_SRC];
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 en_q, en_d;
    logic [RoB_WIDTH-1:0] index_q, index_d;
    logic [31:0]          data_q, data_d;
    logic                 ovf_q, ovf_d;

    logic                 grant_valid;
    logic [SRC_W-1:0]     grant_src;
    logic [SRC_W-1:0]     scan_src;
    logic [N_SRC-1:0]     pop;
    logic [N_SRC-1:0]     accept;

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] v);
        return (int'(v) == N_SRC - 1) ? '0 : v + SRC_W'(1);
    endfunction

    // Scan from rr_ptr upward; the first non-empty FIFO wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = '0;
        scan_src    = rr_ptr_q;
        for (int k = 0; k < N_SRC; k++) begin
            if (!grant_valid && (count_q[scan_src] != '0)) begin
                grant_valid = 1'b1;
                grant_src   = scan_src;
            end
            scan_src = wrap_inc(scan_src);
        end
    end

    always_comb begin
        mem_idx_d  = mem_idx_q;
        mem_data_d = mem_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        rr_ptr_d   = rr_ptr_q;
        en_d       = en_q;
        index_d    = index_q;
        data_d     = data_q;
        ovf_d      = ovf_q;
        pop        = '0;
        accept     = '0;

        if (rdy_in) begin
            if (flush_signal) begin
                for (int i = 0; i < N_SRC; i++) begin
                    rd_ptr_d[i] = '0;
                    wr_ptr_d[i] = '0;
                    count_d[i]  = '0;
                end
                rr_ptr_d = '0;
                en_d     = 1'b0;
            end else begin
                en_d = grant_valid;
                if (grant_valid) begin
                    rr_ptr_d = wrap_inc(grant_src);
                end
                for (int i = 0; i < N_SRC; i++) begin
                    pop[i]    = grant_valid && (grant_src == SRC_W'(i));
                    // Fullness is judged at cycle start, so a same-cycle pop frees nothing.
                    accept[i] = src_push[i] && (count_q[i] < C_DEPTH);
                    if (src_push[i] && !accept[i]) begin
                        ovf_d = 1'b1;
                    end
                    if (pop[i]) begin
                        index_d     = mem_idx_q[i][rd_ptr_q[i]];
                        data_d      = mem_data_q[i][rd_ptr_q[i]];
                        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                    end
                    if (accept[i]) begin
                        mem_idx_d[i][wr_ptr_q[i]]  = src_index[i*RoB_WIDTH +: RoB_WIDTH];
                        mem_data_d[i][wr_ptr_q[i]] = src_data[i*32 +: 32];
                        wr_ptr_d[i]                = wr_ptr_q[i] + PTR_W'(1);
                    end
                    if (accept[i] && !pop[i]) begin
                        count_d[i] = count_q[i] + CNT_W'(1);
                    end else if (pop[i] && !accept[i]) begin
                        count_d[i] = count_q[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < N_SRC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_idx_q[i][j]  <= '0;
                    mem_data_q[i][j] <= '0;
                end
            end
            rr_ptr_q <= '0;
            en_q     <= 1'b0;
            index_q  <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_idx_q  <= mem_idx_d;
            mem_data_q <= mem_data_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            en_q       <= en_d;
            index_q    <= index_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        src_full = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_full[i] = (count_q[i] == C_DEPTH);
        end
    end

    assign overflow_err     = ovf_q;
    assign CDB_update_en    = en_q;
    assign CDB_update_index = index_q;
    assign CDB_update_data  = data_q;

endmodule
`default_nettype wire
